serial_add_seq: RTL and testbench



---
 rtl/serial_add_seq.sv | 133 +++++++++++++
 tb/tb_serial_add_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder slice, LSB first, WIDTH+1 cycles per result.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   ra_q;
    logic [WIDTH-1:0]   rb_q;
    // The lowest partial-sum bit is shifted out on the final cycle, so it is never stored.
    logic [WIDTH-1:1]   ps_q;
    logic               c_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               bit_s;
    logic               bit_co;
    logic               last_bit;
    logic [WIDTH-1:0]   ps_d;
    logic [WIDTH-1:0]   ra_d;
    logic [WIDTH-1:0]   rb_d;

    assign bit_s    = ra_q[0] ^ rb_q[0] ^ c_q;
    assign bit_co   = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign ps_d     = {bit_s, ps_q};
    assign ra_d     = {1'b0, ra_q[WIDTH-1:1]};
    assign rb_d     = {1'b0, rb_q[WIDTH-1:1]};

    // NOTE: every register here uses <= so all of them sample pre-edge values;
    // the async reset clears the complete datapath, not just the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            ps_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        c_q     <= cin;
                        ps_q    <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    ra_q  <= ra_d;
                    rb_q  <= rb_d;
                    ps_q  <= ps_d[WIDTH-1:1];
                    c_q   <= bit_co;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        sum_q   <= ps_d;
                        cout_q  <= bit_co;
                        // Carry into the MSB differs from carry out of it on signed overflow.
                        ovf_q   <= c_q ^ bit_co;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: reference model plus result scoreboard.
// Define SERIAL_ADD_OVF_EN to also check the ovf port.
module tb_serial_add_seq;

    localparam int W = 8;

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;
    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] sum;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int      n_checks = 0;
    int      n_errors = 0;
    res_t    sb[$];
    res_t    m_hold = '0;
    mstate_t m_state = M_IDLE;
    int      m_cnt = 0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic res_t expect_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] full;
        res_t r;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return r;
    endfunction

    // Cycle model: decides acceptance and queues the arithmetic result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            m_hold  = '0;
            sb.delete();
        end else begin
            case (m_state)
                M_RUN: begin
                    m_cnt++;
                    if (m_cnt == W) m_state = M_DONE;
                end
                default: begin
                    if (start) begin
                        sb.push_back(expect_of(a, b, cin));
                        m_state = M_RUN;
                        m_cnt   = 0;
                    end else begin
                        m_state = M_IDLE;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        res_t e;
        check("ready", ready, m_state != M_RUN);
        check("busy", busy, m_state == M_RUN);
        check("done", done, m_state == M_DONE);
        if (done) begin
            check("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                m_hold = e;
            end
        end
        check("sum", sum, m_hold.sum);
        check("cout", cout, m_hold.cout);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", ovf, m_hold.ovf);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int n = 0;
        while (!ready && n < 4 * W) begin
            tick();
            n++;
        end
        check("ready_wait", ready, 1);
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = ci;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 4 * W);
        check("done_timeout", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   n;
        logic [W-1:0] prev;

        repeat (3) tick();
        check("rst_ready", ready, 1);
        check("rst_sum", sum, 0);
        rst_n = 1'b1;
        tick();

        // Basic add; done rises on the W-th edge after the start edge.
        do_op(8'h5A, 8'h33, 1'b0);
        wait_done(lat);
        check("t1_latency", lat, W);
        check("t1_sum", sum, 8'h8D);
        check("t1_cout", cout, 0);
        repeat (3) tick();
        check("t1_hold", sum, 8'h8D);

        do_op(8'hFF, 8'h00, 1'b1);
        wait_done(lat);
        check("t2_sum", sum, 8'h00);
        check("t2_cout", cout, 1);
`ifdef SERIAL_ADD_OVF_EN
        do_op(8'h7F, 8'h01, 1'b0);
        wait_done(lat);
        check("t2_ovf_sum", sum, 8'h80);
        check("t2_ovf_set", ovf, 1);
        do_op(8'hFF, 8'h01, 1'b0);
        wait_done(lat);
        check("t2_ovf_clr", ovf, 0);
`endif

        // start during RUN must be ignored.
        do_op(8'h12, 8'h34, 1'b0);
        repeat (2) tick();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        tick();
        start = 1'b0;
        check("t3_busy", busy, 1);
        wait_done(lat);
        check("t3_latency", lat, W - 3);
        check("t3_sum", sum, 8'h46);
        tick();
        check("t3_no_second", done, 0);

        // Back-to-back: start held in the DONE cycle.
        do_op(8'h10, 8'h20, 1'b0);
        wait_done(lat);
        prev = sum;
        check("t4_first", prev, 8'h30);
        do_op(8'h01, 8'h02, 1'b0);
        check("t4_busy", busy, 1);
        check("t4_prev_held", sum, 8'h30);
        wait_done(lat);
        check("t4_latency", lat, W);
        check("t4_sum", sum, 8'h03);

        // Asynchronous reset mid-RUN.
        do_op(8'hAA, 8'h55, 1'b1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t5_sum", sum, 0);
        check("t5_cout", cout, 0);
        check("t5_ready", ready, 1);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (W + 2) begin
            tick();
            check("t5_no_done", done, 0);
        end
        do_op(8'hC8, 8'h64, 1'b1);
        wait_done(lat);
        check("t5_fresh_sum", sum, 8'h2D);
        check("t5_fresh_cout", cout, 1);

        // Random traffic with random gaps; scoreboard checks every result.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end
        n = 0;
        while ((sb.size() > 0 || busy) && n < 4 * W) begin
            tick();
            n++;
        end
        tick();
        check("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
